// File: rtl/jesd204_frame_mark_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : jesd204_frame_mark_gen_if
// Brief    : Link-side control and per-octet boundary marks of the frame mark
//            sequencer. frame_cnt exists only with JESD204_FRAME_MARK_FRAME_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface jesd204_frame_mark_gen_if #(
    parameter int DATA_PATH_WIDTH = 4
);
    logic [7:0]                 cfg_octets_per_frame;
    logic [9:0]                 cfg_octets_per_multiframe;
    logic                       enable;
    logic                       start;
    logic                       running;
    logic [DATA_PATH_WIDTH-1:0] sof;
    logic [DATA_PATH_WIDTH-1:0] eof;
    logic [DATA_PATH_WIDTH-1:0] somf;
    logic [DATA_PATH_WIDTH-1:0] eomf;
`ifdef JESD204_FRAME_MARK_FRAME_CNT_EN
    logic [15:0]                frame_cnt;

    modport master (
        output cfg_octets_per_frame, cfg_octets_per_multiframe, enable, start,
        input  running, sof, eof, somf, eomf, frame_cnt
    );
    modport slave (
        input  cfg_octets_per_frame, cfg_octets_per_multiframe, enable, start,
        output running, sof, eof, somf, eomf, frame_cnt
    );
`else
    modport master (
        output cfg_octets_per_frame, cfg_octets_per_multiframe, enable, start,
        input  running, sof, eof, somf, eomf
    );
    modport slave (
        input  cfg_octets_per_frame, cfg_octets_per_multiframe, enable, start,
        output running, sof, eof, somf, eomf
    );
`endif
endinterface
`default_nettype wire

// File: rtl/jesd204_frame_mark_gen.sv
`default_nettype none
// ============================================================================
// Module   : jesd204_frame_mark_gen
// Brief    : Per-octet sof/eof/somf/eomf sequencer for one JESD204 link.
//            Optional macro JESD204_FRAME_MARK_FRAME_CNT_EN adds frame_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module jesd204_frame_mark_gen #(
    parameter int DATA_PATH_WIDTH           = 4,
    parameter int MAX_OCTETS_PER_MULTIFRAME = 1024
) (
    input  wire logic                   clk,
    input  wire logic                   resetn,
    jesd204_frame_mark_gen_if.slave     bus
);
    localparam int c_MPOS_W = $clog2(MAX_OCTETS_PER_MULTIFRAME);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                     r_state;
    logic [7:0]                 r_f_last;
    logic [7:0]                 r_fpos;
    logic [c_MPOS_W-1:0]        r_m_last;
    logic [c_MPOS_W-1:0]        r_mpos;
    logic                       r_running;
    logic [DATA_PATH_WIDTH-1:0] r_sof;
    logic [DATA_PATH_WIDTH-1:0] r_eof;
    logic [DATA_PATH_WIDTH-1:0] r_somf;
    logic [DATA_PATH_WIDTH-1:0] r_eomf;

    logic [DATA_PATH_WIDTH-1:0] w_sof;
    logic [DATA_PATH_WIDTH-1:0] w_eof;
    logic [DATA_PATH_WIDTH-1:0] w_somf;
    logic [DATA_PATH_WIDTH-1:0] w_eomf;
    logic [7:0]                 w_fpos_next;
    logic [c_MPOS_W-1:0]        w_mpos_next;
    logic [c_MPOS_W-1:0]        w_cfg_m_last;
    logic                       w_accept;

    assign w_accept     = bus.enable && bus.start;
    assign w_cfg_m_last = c_MPOS_W'(bus.cfg_octets_per_multiframe);

    // Walk the beat octet by octet so any F or K*F, even smaller than the
    // beat, wraps correctly; >= keeps a bad limit from running the count away.
    always_comb begin
        logic [7:0]          fp;
        logic [c_MPOS_W-1:0] mp;
        fp     = r_fpos;
        mp     = r_mpos;
        w_sof  = '0;
        w_eof  = '0;
        w_somf = '0;
        w_eomf = '0;
        for (int i = 0; i < DATA_PATH_WIDTH; i++) begin
            w_sof[i]  = (fp == 8'd0);
            w_eof[i]  = (fp == r_f_last);
            w_somf[i] = (mp == '0);
            w_eomf[i] = (mp == r_m_last);
            fp = (fp >= r_f_last) ? 8'd0 : fp + 8'd1;
            mp = (mp >= r_m_last) ? '0 : mp + c_MPOS_W'(1);
        end
        w_fpos_next = fp;
        w_mpos_next = mp;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_f_last  <= '0;
            r_m_last  <= '0;
            r_fpos    <= '0;
            r_mpos    <= '0;
            r_running <= 1'b0;
            r_sof     <= '0;
            r_eof     <= '0;
            r_somf    <= '0;
            r_eomf    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_running <= 1'b0;
                    r_sof     <= '0;
                    r_eof     <= '0;
                    r_somf    <= '0;
                    r_eomf    <= '0;
                    if (w_accept) begin
                        r_state  <= ST_RUN;
                        r_f_last <= bus.cfg_octets_per_frame;
                        r_m_last <= w_cfg_m_last;
                        r_fpos   <= '0;
                        r_mpos   <= '0;
                    end
                end
                ST_RUN: begin
                    if (!bus.enable) begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                        r_sof     <= '0;
                        r_eof     <= '0;
                        r_somf    <= '0;
                        r_eomf    <= '0;
                        r_fpos    <= '0;
                        r_mpos    <= '0;
                    end else begin
                        r_running <= 1'b1;
                        r_sof     <= w_sof;
                        r_eof     <= w_eof;
                        r_somf    <= w_somf;
                        r_eomf    <= w_eomf;
                        if (bus.start) begin
                            r_f_last <= bus.cfg_octets_per_frame;
                            r_m_last <= w_cfg_m_last;
                            r_fpos   <= '0;
                            r_mpos   <= '0;
                        end else begin
                            r_fpos   <= w_fpos_next;
                            r_mpos   <= w_mpos_next;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.running = r_running;
    assign bus.sof     = r_sof;
    assign bus.eof     = r_eof;
    assign bus.somf    = r_somf;
    assign bus.eomf    = r_eomf;

`ifdef JESD204_FRAME_MARK_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] w_eof_cnt;

    always_comb begin
        w_eof_cnt = '0;
        for (int i = 0; i < DATA_PATH_WIDTH; i++) begin
            w_eof_cnt = w_eof_cnt + {15'd0, w_eof[i]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_frame_cnt <= '0;
        end else if (w_accept) begin
            r_frame_cnt <= '0;
        end else if (r_state == ST_RUN && bus.enable) begin
            r_frame_cnt <= r_frame_cnt + w_eof_cnt;
        end
    end

    assign bus.frame_cnt = r_frame_cnt;
`endif
endmodule
`default_nettype wire

// File: doc/jesd204_frame_mark_gen.md
Name: jesd204_frame_mark_gen

Overview:
- Sequencer that produces the per-octet frame and multiframe boundary marks (sof/eof/somf/eomf) consumed by the frame align/replace datapath, the RX char-replacement logic and the TX alignment-character insertion.
- Started by a link-layer start pulse; tracks octet position across beats for arbitrary F and K*F, independent of DATA_PATH_WIDTH.
- Sits between the link state machine and the lane datapath, one instance per link.

Parameters:
- DATA_PATH_WIDTH, 4, octets per beat; legal values are 4 and 8.
- MAX_OCTETS_PER_MULTIFRAME, 1024, upper bound of K*F; sets the multiframe counter width to clog2 of this value.

Ports:
- clk  input  1  link clock
- resetn  input  1  asynchronous active-low reset
- cfg_octets_per_frame  input  8  F-1
- cfg_octets_per_multiframe  input  10  K*F-1; must be a multiple of F minus 1
- enable  input  1  level; low forces IDLE
- start  input  1  single-cycle pulse; octet 0 of frame 0 is byte 0 of the next beat
- running  output  1  high while in RUN
- sof  output  DATA_PATH_WIDTH  start-of-frame per octet
- eof  output  DATA_PATH_WIDTH  end-of-frame per octet
- somf  output  DATA_PATH_WIDTH  start-of-multiframe per octet
- eomf  output  DATA_PATH_WIDTH  end-of-multiframe per octet

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; running=0; sof/eof/somf/eomf=0; both position counters=0.
- States:
  - IDLE: outputs 0.
  - IDLE->RUN on enable && start.
  - RUN->IDLE on !enable. Outputs are 0 on the next edge and counters clear.
  - start in RUN: re-aligns. Counters are reloaded to 0 and the next beat again begins at frame and multiframe octet 0.
  - start with enable low is ignored.
- Configuration is latched on the accepted start. Changes during RUN have no effect until the next start.
- Position registers:
  - fpos: 0..F-1, octet index within frame of byte 0 of the beat.
  - mpos: 0..K*F-1, same index within multiframe.
- Per-beat mark generation, for byte i with p = byte position:
  - Bytes take p = fpos+i, wrapping to 0 when p reaches F; sequential wrap applied per byte.
  - sof[i] = (p==0); eof[i] = (p==F-1).
  - somf[i] and eomf[i] are computed identically from mpos against K*F.
- Position advance: after each beat, fpos and mpos take the wrapped value one past the last byte. This is correct for F < DATA_PATH_WIDTH, including F=1, where every byte is both sof and eof.
- All outputs are registered. Latency: start sampled at edge N gives running=1 and the first marks (byte 0: sof=1, somf=1) on outputs after edge N+1, aligned to the beat following start.
- Whenever somf[i]=1, sof[i]=1 and the prior octet's eof/eomf are consistent. This holds provided the cfg multiple rule is met; a violating cfg gives a defined but unaligned pattern and must not hang.
- Counter widths never overflow: wrap comparisons use >= on latched limits.

Optional Feature:
- Macro: JESD204_FRAME_MARK_FRAME_CNT_EN.
- With the macro defined:
  - Adds output frame_cnt, 16 bits.
  - Resets to 0 on resetn and on every accepted start.
  - In RUN it increments each beat by popcount(eof), wrapping modulo 2^16.
  - Holds its value in IDLE.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- DATA_PATH_WIDTH=4, F=2 (cfg 1), K*F=8 (cfg 7), start: eof=4'b1010 and sof=4'b0101 every beat; somf=4'b0001 on beats 0,2,4..; eomf=4'b1000 on beats 1,3,5..; somf and eomf are 0 on the other beats.
- DATA_PATH_WIDTH=4, F=3, K*F=12: sof sequence 1001, 0100, 0010, repeating; eof 0100, 0010, 1001; somf=0001 and eomf=1000 every 3rd beat starting at beat 0 and beat 2 respectively.
- F=1 (cfg 0), K*F=4: sof=eof=4'b1111 every beat; somf=0001 and eomf=1000 every beat.
- Mid-run start after 5 beats with F=3: the next beat restarts the pattern at sof=1001 and somf=0001. Deasserting enable gives all outputs 0 and running=0 one cycle later. Changing cfg in RUN does not alter the pattern.
- resetn asserted asynchronously between edges during RUN: outputs 0 immediately. After release, no marks appear until a new start.
- With JESD204_FRAME_MARK_FRAME_CNT_EN, F=2, DATA_PATH_WIDTH=8: frame_cnt reads 4, 8, 12 after 1, 2, 3 beats. It wraps 0xFFFC->0x0000. It clears on start.
